// File: rtl/argmax_result_checker_if.sv
// Bus bundle for the argmax result checker: result word, label stream,
// verdict stream and accuracy readout.
interface argmax_result_checker_if #(
    parameter int DATA_WIDTH  = 32,
    parameter int COUNT_WIDTH = 32
);
    logic [DATA_WIDTH:0]    in_result;
    logic                   label_valid;
    logic [DATA_WIDTH-1:0]  label_data;
    logic                   label_ready;
    logic                   out_valid;
    logic                   out_ready;
    logic [DATA_WIDTH-1:0]  out_index;
    logic [DATA_WIDTH-1:0]  out_label;
    logic                   out_match;
    logic [COUNT_WIDTH-1:0] total_count;
    logic [COUNT_WIDTH-1:0] correct_count;
    logic                   overflow;
    logic                   clear;

    modport master (
        output in_result, label_valid, label_data, out_ready, clear,
        input  label_ready, out_valid, out_index, out_label, out_match,
               total_count, correct_count, overflow
    );

    modport slave (
        input  in_result, label_valid, label_data, out_ready, clear,
        output label_ready, out_valid, out_index, out_label, out_match,
               total_count, correct_count, overflow
    );
endinterface

// File: rtl/argmax_result_checker.sv
// Buffers argmax results and ground-truth labels, pairs them in order and
// emits per-sample verdicts plus saturating total/correct counters.
module argmax_result_checker #(
    parameter int DATA_WIDTH   = 32,
    parameter int RESULT_DEPTH = 8,
    parameter int LABEL_DEPTH  = 8,
    parameter int COUNT_WIDTH  = 32
) (
    input logic clk,
    input logic rst_n,
    argmax_result_checker_if.slave bus
);
    localparam int RAW = $clog2(RESULT_DEPTH);
    localparam int LAW = $clog2(LABEL_DEPTH);
    localparam int RCW = RAW + 1;
    localparam int LCW = LAW + 1;

    typedef enum logic {IDLE, HOLD} state_t;

    logic [DATA_WIDTH-1:0]  r_res_mem [RESULT_DEPTH];
    logic [DATA_WIDTH-1:0]  r_lbl_mem [LABEL_DEPTH];
    logic [RAW-1:0]         r_res_wr, r_res_rd;
    logic [LAW-1:0]         r_lbl_wr, r_lbl_rd;
    logic [RCW-1:0]         r_res_cnt;
    logic [LCW-1:0]         r_lbl_cnt;
    logic                   r_label_ready;
    state_t                 r_state;
    logic                   r_out_valid;
    logic [DATA_WIDTH-1:0]  r_out_index, r_out_label;
    logic                   r_out_match;
    logic [COUNT_WIDTH-1:0] r_total, r_correct;
    logic                   r_overflow;

    logic             w_done, w_res_full, w_pop, w_res_push, w_res_drop, w_lbl_push, w_hs;
    logic [LCW-1:0]   w_lbl_cnt_nxt;

    assign w_done     = bus.in_result[DATA_WIDTH];
    assign w_res_full = (r_res_cnt == RCW'(RESULT_DEPTH));
    assign w_hs       = r_out_valid && bus.out_ready;
    // A pair is taken whenever both sides have data and the output slot is free
    // or being freed this cycle, giving one verdict per cycle under streaming.
    assign w_pop      = (r_res_cnt != '0) && (r_lbl_cnt != '0) && (r_state == IDLE || bus.out_ready);
    assign w_res_push = w_done && (!w_res_full || w_pop);
    assign w_res_drop = w_done && w_res_full && !w_pop;
    assign w_lbl_push = bus.label_valid && r_label_ready;
    assign w_lbl_cnt_nxt = r_lbl_cnt + LCW'(w_lbl_push) - LCW'(w_pop);

    always_ff @(posedge clk) begin
        if (w_res_push) r_res_mem[r_res_wr] <= bus.in_result[DATA_WIDTH-1:0];
        if (w_lbl_push) r_lbl_mem[r_lbl_wr] <= bus.label_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res_wr      <= '0;
            r_res_rd      <= '0;
            r_res_cnt     <= '0;
            r_lbl_wr      <= '0;
            r_lbl_rd      <= '0;
            r_lbl_cnt     <= '0;
            r_label_ready <= 1'b1;
        end else begin
            if (w_res_push) r_res_wr <= r_res_wr + RAW'(1);
            if (w_pop)      r_res_rd <= r_res_rd + RAW'(1);
            r_res_cnt <= r_res_cnt + RCW'(w_res_push) - RCW'(w_pop);
            if (w_lbl_push) r_lbl_wr <= r_lbl_wr + LAW'(1);
            if (w_pop)      r_lbl_rd <= r_lbl_rd + LAW'(1);
            r_lbl_cnt     <= w_lbl_cnt_nxt;
            r_label_ready <= (w_lbl_cnt_nxt != LCW'(LABEL_DEPTH));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_out_index <= '0;
            r_out_label <= '0;
            r_out_match <= 1'b0;
        end else begin
            if (w_pop) begin
                r_out_index <= r_res_mem[r_res_rd];
                r_out_label <= r_lbl_mem[r_lbl_rd];
                r_out_match <= (r_res_mem[r_res_rd] == r_lbl_mem[r_lbl_rd]);
            end
            case (r_state)
                IDLE: if (w_pop) begin
                    r_out_valid <= 1'b1;
                    r_state     <= HOLD;
                end
                HOLD: if (bus.out_ready && !w_pop) begin
                    r_out_valid <= 1'b0;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // clear takes priority over a same-cycle handshake and overflow event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_total    <= '0;
            r_correct  <= '0;
            r_overflow <= 1'b0;
        end else if (bus.clear) begin
            r_total    <= '0;
            r_correct  <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_hs && r_total != '1) r_total <= r_total + COUNT_WIDTH'(1);
            if (w_hs && r_out_match && r_correct != '1) r_correct <= r_correct + COUNT_WIDTH'(1);
            if (w_res_drop) r_overflow <= 1'b1;
        end
    end

    assign bus.label_ready   = r_label_ready;
    assign bus.out_valid     = r_out_valid;
    assign bus.out_index     = r_out_index;
    assign bus.out_label     = r_out_label;
    assign bus.out_match     = r_out_match;
    assign bus.total_count   = r_total;
    assign bus.correct_count = r_correct;
    assign bus.overflow      = r_overflow;
endmodule
